// File: rtl/alu_decode_stage_pkg.sv
// Shared RV32I opcode and ALUop encodings plus the decoded-entry layout
// used by the decode stage and its skid buffer.
package alu_decode_stage_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_COPY_B = 4'd10,
      ALU_XXX    = 4'd15
   } aluop_e;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   typedef struct packed {
      aluop_e aluop;
      logic   a_sel;
      logic   b_sel;
      logic   illegal;
   } dec_t;

   localparam dec_t DEC_RESET = '{aluop: ALU_XXX, a_sel: 1'b0, b_sel: 1'b0, illegal: 1'b0};

   // funct3 mapping shared by OP and OP-IMM before the funct7[5] alternates.
   function automatic aluop_e base_op(input logic [2:0] funct3);
      case (funct3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/alu_decode_stage_op_decode.sv
// Purely combinational RV32I instruction -> ALUop / operand-select decode.
// Unsupported opcodes or OP funct7 values yield ALU_XXX with illegal set.
module alu_op_decode
   import alu_decode_stage_pkg::*;
(
   input  logic [31:0] inst_i,
   output logic [3:0]  aluop_o,
   output logic        a_sel_o,
   output logic        b_sel_o,
   output logic        illegal_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode        = inst_i[6:0];
   assign funct3        = inst_i[14:12];
   assign funct7        = inst_i[31:25];
   assign unused_fields = ^{inst_i[24:15], inst_i[11:7]};

   always_comb begin
      aluop_o   = ALU_XXX;
      a_sel_o   = 1'b0;
      b_sel_o   = 1'b0;
      illegal_o = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
               aluop_o = base_op(funct3);
               if (funct7[5] && funct3 == 3'b000) aluop_o = ALU_SUB;
               if (funct7[5] && funct3 == 3'b101) aluop_o = ALU_SRA;
            end else begin
               illegal_o = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            // funct7 overlaps the immediate here, so only SRAI may consult it.
            aluop_o = base_op(funct3);
            b_sel_o = 1'b1;
            if (funct7[5] && funct3 == 3'b101) aluop_o = ALU_SRA;
         end
         OPC_LOAD, OPC_STORE, OPC_JALR: begin
            aluop_o = ALU_ADD;
            b_sel_o = 1'b1;
         end
         OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
            aluop_o = ALU_ADD;
            a_sel_o = 1'b1;
            b_sel_o = 1'b1;
         end
         OPC_LUI: begin
            aluop_o = ALU_COPY_B;
            b_sel_o = 1'b1;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: instructions are decoded on entry and held in a 2-entry skid buffer.
// One-cycle latency; in_ready is registered and drops only while both entries are occupied.
module alu_decode_stage
   import alu_decode_stage_pkg::*;
#(
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [INST_W-1:0] in_inst,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_aluop,
   output logic              out_a_sel,
   output logic              out_b_sel,
   output logic              out_illegal
);

   logic [3:0] dec_aluop;
   logic       dec_a_sel;
   logic       dec_b_sel;
   logic       dec_illegal;
   dec_t       dec_in;

   state_e     state_q;
   dec_t       head_q;
   dec_t       skid_q;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       push;
   logic       pop;

   alu_op_decode u_op_decode (
      .inst_i    (in_inst[31:0]),
      .aluop_o   (dec_aluop),
      .a_sel_o   (dec_a_sel),
      .b_sel_o   (dec_b_sel),
      .illegal_o (dec_illegal)
   );

   assign dec_in = '{aluop: aluop_e'(dec_aluop), a_sel: dec_a_sel,
                     b_sel: dec_b_sel, illegal: dec_illegal};

   assign push = in_valid & in_ready_q;
   assign pop  = out_valid_q & out_ready;

   // head_q is always the entry on out_*; skid_q holds the younger one when FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         head_q      <= DEC_RESET;
         skid_q      <= DEC_RESET;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         in_ready_q <= 1'b1;
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  head_q      <= dec_in;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (push && !pop) begin
                  skid_q     <= dec_in;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_FULL;
               end else if (!push && pop) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_EMPTY;
               end else if (push && pop) begin
                  head_q <= dec_in;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  head_q  <= skid_q;
                  state_q <= ST_ONE;
               end else begin
                  in_ready_q <= 1'b0;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_EMPTY;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_aluop   = head_q.aluop;
   assign out_a_sel   = head_q.a_sel;
   assign out_b_sel   = head_q.b_sel;
   assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed instructions feed a scoreboard queue,
// a negedge monitor pops and compares each delivered entry.
module tb_alu_decode_stage;
   import alu_decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_inst = 32'd0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_aluop;
   logic        out_a_sel;
   logic        out_b_sel;
   logic        out_illegal;

   typedef struct packed {
      logic [3:0] op;
      logic       a;
      logic       b;
      logic       ill;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] vec_inst[16];
   exp_t        vec_exp[16];

   alu_decode_stage #(.INST_W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_inst     (in_inst),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_aluop   (out_aluop),
      .out_a_sel   (out_a_sel),
      .out_b_sel   (out_b_sel),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [3:0] op, input logic a, input logic b, input logic ill);
      mk = '{op: op, a: a, b: b, ill: ill};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every transfer on the output side must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got aluop 0x%0h with no entry expected at %0t",
                     out_aluop, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("entry", 32'({out_aluop, out_a_sel, out_b_sel, out_illegal}), 32'(mon_e));
         end
      end
   end

   task automatic send(input logic [31:0] inst, input exp_t e);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_inst  = inst;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: inst 0x%08h not accepted within 50 cycles", inst);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && sb_q.size() != 0; n++) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d entries still pending, expected 0", sb_q.size());
         sb_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_inst[0]  = 32'h003100B3; vec_exp[0]  = mk(ALU_ADD,    1'b0, 1'b0, 1'b0); // add
      vec_inst[1]  = 32'h403100B3; vec_exp[1]  = mk(ALU_SUB,    1'b0, 1'b0, 1'b0); // sub
      vec_inst[2]  = 32'h40315093; vec_exp[2]  = mk(ALU_SRA,    1'b0, 1'b1, 1'b0); // srai
      vec_inst[3]  = 32'hC0010093; vec_exp[3]  = mk(ALU_ADD,    1'b0, 1'b1, 1'b0); // addi -1024
      vec_inst[4]  = 32'h123450B7; vec_exp[4]  = mk(ALU_COPY_B, 1'b0, 1'b1, 1'b0); // lui
      vec_inst[5]  = 32'h0000007F; vec_exp[5]  = mk(ALU_XXX,    1'b0, 1'b0, 1'b1); // bad opcode
      vec_inst[6]  = 32'h00012083; vec_exp[6]  = mk(ALU_ADD,    1'b0, 1'b1, 1'b0); // lw
      vec_inst[7]  = 32'h00208463; vec_exp[7]  = mk(ALU_ADD,    1'b1, 1'b1, 1'b0); // beq
      vec_inst[8]  = 32'h023100B3; vec_exp[8]  = mk(ALU_XXX,    1'b0, 1'b0, 1'b1); // mul
      vec_inst[9]  = 32'h0031B0B3; vec_exp[9]  = mk(ALU_SLTU,   1'b0, 1'b0, 1'b0); // sltu
      vec_inst[10] = 32'h0FF16093; vec_exp[10] = mk(ALU_OR,     1'b0, 1'b1, 1'b0); // ori
      vec_inst[11] = 32'h00315093; vec_exp[11] = mk(ALU_SRL,    1'b0, 1'b1, 1'b0); // srli
      vec_inst[12] = 32'h403150B3; vec_exp[12] = mk(ALU_SRA,    1'b0, 1'b0, 1'b0); // sra
      vec_inst[13] = 32'h008000EF; vec_exp[13] = mk(ALU_ADD,    1'b1, 1'b1, 1'b0); // jal
      vec_inst[14] = 32'h00001097; vec_exp[14] = mk(ALU_ADD,    1'b1, 1'b1, 1'b0); // auipc
      vec_inst[15] = 32'h00112223; vec_exp[15] = mk(ALU_ADD,    1'b0, 1'b1, 1'b0); // sw

      // Reset values and in_ready release timing.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid",   32'(out_valid),   32'd0);
      chk("rst_in_ready",    32'(in_ready),    32'd0);
      chk("rst_out_aluop",   32'(out_aluop),   32'hF);
      chk("rst_out_a_sel",   32'(out_a_sel),   32'd0);
      chk("rst_out_b_sel",   32'(out_b_sel),   32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 chk("in_ready_after_edge", 32'(in_ready), 32'd1);

      // Streaming decode with the sink always ready; first one checks latency.
      out_ready = 1'b1;
      send(vec_inst[0], vec_exp[0]);
      chk("latency_out_valid", 32'(out_valid), 32'd1);
      for (int i = 1; i < 16; i++) send(vec_inst[i], vec_exp[i]);
      drain();

      // Backpressure: two accepted, third waits until the sink releases.
      out_ready = 1'b0;
      fork
         begin
            send(vec_inst[1], vec_exp[1]);
            send(vec_inst[4], vec_exp[4]);
            send(vec_inst[10], vec_exp[10]);
         end
         begin
            repeat (3) @(negedge clk);
            chk("full_in_ready",  32'(in_ready),  32'd0);
            chk("full_out_valid", 32'(out_valid), 32'd1);
            chk("full_oldest",    32'(out_aluop), 32'(ALU_SUB));
            repeat (2) @(negedge clk);
            chk("hold_aluop",    32'(out_aluop), 32'(ALU_SUB));
            chk("hold_b_sel",    32'(out_b_sel), 32'd0);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Flush while FULL with an instruction offered.
      out_ready = 1'b0;
      send(32'h003100B3, mk(ALU_ADD, 1'b0, 1'b0, 1'b0));
      send(32'h003110B3, mk(ALU_SLL, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b1;
      in_inst  = 32'h003140B3;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("flush_full_out_valid", 32'(out_valid), 32'd0);
      chk("flush_full_in_ready",  32'(in_ready),  32'd1);

      // Flush in ONE overrides an input that would otherwise be accepted.
      send(32'h003170B3, mk(ALU_AND, 1'b0, 1'b0, 1'b0));
      in_valid = 1'b1;
      in_inst  = 32'h003140B3;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_one_out_valid", 32'(out_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("flush_not_stored", 32'(out_valid), 32'd0);

      // Asynchronous reset mid-cycle while holding one entry.
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      send(32'h003170B3, mk(ALU_AND, 1'b0, 1'b0, 1'b0));
      chk("one_before_reset", 32'(out_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_in_ready",  32'(in_ready),  32'd0);
      chk("async_out_aluop", 32'(out_aluop), 32'hF);
      sb_q.delete();
      #2 rst_n = 1'b1;
      #1 chk("rerelease_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 chk("rerelease_in_ready_high", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      send(vec_inst[7], vec_exp[7]);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
